// File: rtl/if_fetch_ctrl_if.sv
// Instruction-memory request/acknowledge bus between the fetch controller
// (master) and the instruction memory (slave).
interface if_fetch_ctrl_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );
endinterface

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch front end: owns the fetch PC, runs the imem req/ack
// handshake, buffers a returned word across IF/ID stalls and discards
// in-flight or buffered fetches on branch/jump redirects.
module if_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               stall,
   input  logic               redirect_en,
   input  logic [31:0]        redirect_addr,
   if_fetch_ctrl_if.master    imem,
   output logic [31:0]        fetch_inst,
   output logic [31:0]        pc_output,
   output logic [31:0]        npc_output,
   output logic               ifreg_write_en
);

   typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

   state_t      state, state_nxt;
   logic [31:0] fetch_pc, fetch_pc_nxt;
   logic [31:0] hold_inst, hold_inst_nxt;
   logic [31:0] pend_pc, pend_pc_nxt;
   logic [31:0] redirect_pc;
   logic [31:0] seq_pc;
   logic        unused_low;

   // Redirect targets are always word aligned; the low address bits carry no information.
   assign redirect_pc = {redirect_addr[31:2], 2'b00};
   assign unused_low  = ^redirect_addr[1:0];
   assign seq_pc      = fetch_pc + 32'd4;

   // The address stays on fetch_pc in every state, so it is stable for the
   // whole life of a request, including while a redirected fetch drains.
   assign imem.imem_addr = fetch_pc;
   assign pc_output      = fetch_pc;
   assign npc_output     = seq_pc;

   // State and datapath registers.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the values computed before the edge, independent of block order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         fetch_pc  <= RESET_PC;
         // NOTE: hold_inst is reset to a known NOP so a stale buffer can never
         // leak onto fetch_inst after reset; it is a single word, not a memory.
         hold_inst <= NOP_INST;
         pend_pc   <= '0;
      end else begin
         state     <= state_nxt;
         fetch_pc  <= fetch_pc_nxt;
         hold_inst <= hold_inst_nxt;
         pend_pc   <= pend_pc_nxt;
      end
   end

   // Next-state and next-datapath decode.
   always_comb begin
      // NOTE: every variable gets a default first so no path infers a latch.
      state_nxt     = state;
      fetch_pc_nxt  = fetch_pc;
      hold_inst_nxt = hold_inst;
      pend_pc_nxt   = pend_pc;
      case (state)
         IDLE: begin
            state_nxt = FETCH;
            if (redirect_en) fetch_pc_nxt = redirect_pc;
         end
         FETCH: begin
            if (imem.imem_ack) begin
               if (redirect_en) begin
                  fetch_pc_nxt = redirect_pc;
               end else if (stall) begin
                  hold_inst_nxt = imem.imem_rdata;
                  state_nxt     = HOLD;
               end else begin
                  fetch_pc_nxt = seq_pc;
               end
            end else if (redirect_en) begin
               pend_pc_nxt = redirect_pc;
               state_nxt   = DRAIN;
            end
         end
         HOLD: begin
            if (redirect_en) begin
               fetch_pc_nxt  = redirect_pc;
               hold_inst_nxt = NOP_INST;
               state_nxt     = FETCH;
            end else if (!stall) begin
               fetch_pc_nxt = seq_pc;
               state_nxt    = FETCH;
            end
         end
         DRAIN: begin
            // The latest redirect wins, even one arriving with the drain ack.
            if (redirect_en) pend_pc_nxt = redirect_pc;
            if (imem.imem_ack) begin
               fetch_pc_nxt = redirect_en ? redirect_pc : pend_pc;
               state_nxt    = FETCH;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Handshake and IF/ID outputs; delivery is combinational from ack.
   always_comb begin
      imem.imem_req  = 1'b0;
      ifreg_write_en = 1'b0;
      fetch_inst     = NOP_INST;
      case (state)
         FETCH: begin
            imem.imem_req = 1'b1;
            if (imem.imem_ack && !redirect_en && !stall) begin
               ifreg_write_en = 1'b1;
               fetch_inst     = imem.imem_rdata;
            end
         end
         HOLD: begin
            fetch_inst = hold_inst;
            if (!redirect_en && !stall) ifreg_write_en = 1'b1;
         end
         DRAIN:   imem.imem_req = 1'b1;
         default: imem.imem_req = 1'b0;
      endcase
   end

endmodule
